// File: rtl/pu_riscv_ahb32mem_if.sv
// AHB3-Lite slave bus plus generic request/acknowledge memory port, bundled for pu_riscv_ahb32mem.
// The slave modport is the responder's view; the master modport is the bus master and memory side.
interface pu_riscv_ahb32mem_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    localparam int BEW = XLEN / 8;

    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    logic            mem_req_o;
    logic [PLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [BEW-1:0]  mem_be_o;
    logic [3:0]      mem_prot_o;
    logic [XLEN-1:0] mem_d_o;
    logic [XLEN-1:0] mem_q_i;
    logic            mem_ack_i;
    logic            mem_err_i;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY, mem_q_i, mem_ack_i, mem_err_i,
        output HRDATA, HREADYOUT, HRESP, mem_req_o, mem_adr_o, mem_we_o,
               mem_be_o, mem_prot_o, mem_d_o
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY, mem_q_i, mem_ack_i, mem_err_i,
        input  HRDATA, HREADYOUT, HRESP, mem_req_o, mem_adr_o, mem_we_o,
               mem_be_o, mem_prot_o, mem_d_o
    );
endinterface

// File: rtl/pu_riscv_ahb32mem.sv
// AHB3-Lite responder terminating bus transfers onto a registered request/acknowledge memory port.
// Handles pipelined address/data phases, wait states and two-cycle ERROR responses.
module pu_riscv_ahb32mem #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input logic                HCLK,
    input logic                HRESET,
    pu_riscv_ahb32mem_if.slave bus
);
    localparam int BEW = XLEN / 8;
    localparam int SZW = $clog2(BEW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            legal;
    logic            start_access;
    logic            hreadyout;
    logic            hresp;
    logic            mem_req;
    logic [PLEN-1:0] mem_adr;
    logic            mem_we;
    logic [BEW-1:0]  mem_be;
    logic [3:0]      mem_prot;
    logic            unused_ahb;

    function automatic logic size_legal(input logic [2:0] size, input logic [SZW-1:0] off);
        int mask;
        if (int'(size) > SZW) return 1'b0;
        mask = (1 << size) - 1;
        return (int'(off) & mask) == 0;
    endfunction

    function automatic logic [BEW-1:0] byte_en(input logic [2:0] size, input logic [SZW-1:0] off);
        logic [BEW-1:0] be;
        be = '0;
        for (int i = 0; i < BEW; i++)
            be[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
        return be;
    endfunction

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal  = size_legal(bus.HSIZE, bus.HADDR[SZW-1:0]);

    // A new address phase can only be taken where the previous data phase ends with HREADYOUT=1.
    always_comb begin
        state_nxt    = state;
        start_access = 1'b0;
        hreadyout    = 1'b1;
        hresp        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt    = legal ? ST_ACCESS : ST_ERR1;
                    start_access = legal;
                end
            end
            ST_ACCESS: begin
                hreadyout = bus.mem_ack_i & ~bus.mem_err_i;
                if (bus.mem_ack_i) begin
                    if (bus.mem_err_i) begin
                        hresp     = 1'b1;
                        state_nxt = ST_ERR2;
                    end else if (accept) begin
                        state_nxt    = legal ? ST_ACCESS : ST_ERR1;
                        start_access = legal;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
                if (accept) begin
                    state_nxt    = legal ? ST_ACCESS : ST_ERR1;
                    start_access = legal;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured only when a new access starts, so they hold through wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_adr  <= '0;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            mem_prot <= '0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt == ST_ACCESS);
            if (start_access) begin
                mem_adr  <= bus.HADDR;
                mem_we   <= bus.HWRITE;
                mem_be   <= byte_en(bus.HSIZE, bus.HADDR[SZW-1:0]);
                mem_prot <= bus.HPROT;
            end
        end
    end

    assign bus.HREADYOUT  = hreadyout;
    assign bus.HRESP      = hresp;
    assign bus.HRDATA     = (state == ST_ACCESS && bus.mem_ack_i && !bus.mem_err_i && !mem_we)
                            ? bus.mem_q_i : '0;
    assign bus.mem_req_o  = mem_req;
    assign bus.mem_adr_o  = mem_adr;
    assign bus.mem_we_o   = mem_we;
    assign bus.mem_be_o   = mem_be;
    assign bus.mem_prot_o = mem_prot;
    assign bus.mem_d_o    = bus.HWDATA;

    assign unused_ahb = &{1'b0, bus.HBURST, bus.HMASTLOCK};
endmodule
